// File: rtl/gray_pkg.sv
// Shared helpers for the Gray-code counter and its decode channel.
// Functions operate on a fixed-width word; callers zero-extend their
// WIDTH-bit value in and size-cast the result back down. Zero upper bits
// leave both transforms unaffected, so any WIDTH up to GRAY_MAX_W works.
package gray_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  // All-ones value for a w-bit counter (2**w - 1).
  function automatic gray_word_t max_count(input int unsigned w);
    if (w >= GRAY_MAX_W) begin
      return '1;
    end
    return (gray_word_t'(1) << w) - gray_word_t'(1);
  endfunction

  function automatic gray_word_t b2g(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // XOR-prefix from the MSB down: b[i] = b[i+1] ^ g[i].
  function automatic gray_word_t g2b(input gray_word_t g);
    gray_word_t b;
    b = '0;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int unsigned i = GRAY_MAX_W - 1; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_gray2bin_pipe.sv
// Two-stage Gray-to-binary decoder, latency 2, one value per cycle.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   dec_gray     - Gray value to decode
//   dec_in_valid - dec_gray qualifier
//   dec_bin      - decoded binary, holds while no valid value arrives
//   dec_valid    - dec_in_valid delayed by two cycles
module gray2bin_pipe
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dec_gray,
  input  logic             dec_in_valid,
  output logic [WIDTH-1:0] dec_bin,
  output logic             dec_valid
);

  logic [WIDTH-1:0] s1_gray;
  logic             s1_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_gray   <= '0;
      s1_valid  <= 1'b0;
      dec_bin   <= '0;
      dec_valid <= 1'b0;
    end else begin
      s1_gray   <= dec_gray;
      s1_valid  <= dec_in_valid;
      dec_valid <= s1_valid;
      if (s1_valid) begin
        dec_bin <= WIDTH'(g2b(GRAY_MAX_W'(s1_gray)));
      end
    end
  end

endmodule

// File: rtl/gray_counter.sv
// Up/down Gray-code counter with load, wrap/saturate and terminal count,
// plus an independent pipelined Gray-to-binary decode channel.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   en, up       - count enable, direction (1 = increment)
//   load         - synchronous load strobe (overrides en/up)
//   load_bin     - binary value to load
//   bin, gray    - registered count and its Gray code
//   tc           - registered terminal-count pulse
//   dec_gray, dec_in_valid - decoder input and qualifier
//   dec_bin, dec_valid     - decoder output and qualifier
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter bit          WRAP    = 1'b1,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             tc,
  input  logic [WIDTH-1:0] dec_gray,
  input  logic             dec_in_valid,
  output logic [WIDTH-1:0] dec_bin,
  output logic             dec_valid
);

  localparam logic [WIDTH-1:0] MAX_BIN  = WIDTH'(max_count(WIDTH));
  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(b2g(GRAY_MAX_W'(RST_BIN)));

  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic             tc_nxt;

  // tc_nxt is raised for any step that hits a bound, whether it wraps
  // or is blocked; in saturate mode it repeats for each blocked step.
  always_comb begin
    bin_nxt = bin;
    tc_nxt  = 1'b0;
    if (load) begin
      bin_nxt = load_bin;
    end else if (en) begin
      if (up) begin
        if (bin == MAX_BIN) begin
          tc_nxt = 1'b1;
          if (WRAP) begin
            bin_nxt = '0;
          end
        end else begin
          bin_nxt = bin + WIDTH'(1);
        end
      end else begin
        if (bin == '0) begin
          tc_nxt = 1'b1;
          if (WRAP) begin
            bin_nxt = MAX_BIN;
          end
        end else begin
          bin_nxt = bin - WIDTH'(1);
        end
      end
    end
    gray_nxt = WIDTH'(b2g(GRAY_MAX_W'(bin_nxt)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin  <= RST_BIN;
      gray <= RST_GRAY;
      tc   <= 1'b0;
    end else begin
      bin  <= bin_nxt;
      gray <= gray_nxt;
      tc   <= tc_nxt;
    end
  end

  gray2bin_pipe #(
    .WIDTH(WIDTH)
  ) u_dec (
    .clk         (clk),
    .rst         (rst),
    .dec_gray    (dec_gray),
    .dec_in_valid(dec_in_valid),
    .dec_bin     (dec_bin),
    .dec_valid   (dec_valid)
  );

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: a wrapping and a saturating instance share all
// inputs; a behavioural model pushes expected outputs at drive time and
// each scenario pops and compares them after the clock edge.
module tb_gray_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_bin;
  logic [3:0] dec_gray;
  logic       dec_in_valid;

  logic [3:0] w_bin, w_gray, w_dbin;
  logic       w_tc, w_dvalid;
  logic [3:0] s_bin, s_gray, s_dbin;
  logic       s_tc, s_dvalid;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] w_bin;
    logic [3:0] w_gray;
    logic       w_tc;
    logic [3:0] s_bin;
    logic [3:0] s_gray;
    logic       s_tc;
    logic       d_valid;
    logic [3:0] d_bin;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  // Model state
  int m_w, m_s;
  bit m_wtc, m_stc;
  bit m_s1v, m_dv;
  int m_s1b, m_db;

  gray_counter #(.WIDTH(4), .WRAP(1'b1), .RST_VAL(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(load_bin),
    .bin(w_bin), .gray(w_gray), .tc(w_tc),
    .dec_gray(dec_gray), .dec_in_valid(dec_in_valid),
    .dec_bin(w_dbin), .dec_valid(w_dvalid)
  );

  gray_counter #(.WIDTH(4), .WRAP(1'b0), .RST_VAL(0)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(load_bin),
    .bin(s_bin), .gray(s_gray), .tc(s_tc),
    .dec_gray(dec_gray), .dec_in_valid(dec_in_valid),
    .dec_bin(s_dbin), .dec_valid(s_dvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int gray_of(input int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  function automatic int bin_of_gray(input int g);
    int acc = 0;
    int r = 0;
    for (int i = 3; i >= 0; i--) begin
      acc = acc ^ ((g >> i) & 1);
      r = r | (acc << i);
    end
    return r;
  endfunction

  function automatic void cnt_step(inout int b, output bit t, input bit ld,
                                   input int lb, input bit e_, input bit u,
                                   input bit wrap);
    t = 1'b0;
    if (ld) b = lb;
    else if (e_) begin
      if (u) begin
        if (b == 15) begin t = 1'b1; if (wrap) b = 0; end
        else b = b + 1;
      end else begin
        if (b == 0) begin t = 1'b1; if (wrap) b = 15; end
        else b = b - 1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of stimulus, advance the model, push its expectation.
  task automatic drive(input bit r, input bit ld, input int lb, input bit e_,
                       input bit u, input int dg, input bit dv);
    exp_t x;
    rst = r; load = ld; load_bin = 4'(lb); en = e_; up = u;
    dec_gray = 4'(dg); dec_in_valid = dv;
    if (r) begin
      m_w = 0; m_s = 0; m_wtc = 0; m_stc = 0;
      m_s1v = 0; m_s1b = 0; m_dv = 0; m_db = 0;
    end else begin
      cnt_step(m_w, m_wtc, ld, lb, e_, u, 1'b1);
      cnt_step(m_s, m_stc, ld, lb, e_, u, 1'b0);
      m_dv = m_s1v;
      if (m_s1v) m_db = m_s1b;
      m_s1v = dv;
      m_s1b = bin_of_gray(dg);
    end
    x.w_bin = 4'(m_w); x.w_gray = 4'(gray_of(m_w)); x.w_tc = m_wtc;
    x.s_bin = 4'(m_s); x.s_gray = 4'(gray_of(m_s)); x.s_tc = m_stc;
    x.d_valid = m_dv; x.d_bin = 4'(m_db);
    exp_q.push_back(x);
    tick();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      e = exp_q.pop_front();
      checks++;
      if ({w_bin, w_gray, w_tc} !== 9'b0000_0000_0) begin
        errors++;
        $display("FAIL reset_wrap: bin/gray/tc got %h/%b/%b want 0/0000/0", w_bin, w_gray, w_tc);
      end
      checks++;
      if ({s_bin, s_gray, s_tc} !== {e.s_bin, e.s_gray, e.s_tc}) begin
        errors++;
        $display("FAIL reset_sat: bin/gray/tc got %h/%b/%b want %h/%b/%b", s_bin, s_gray, s_tc, e.s_bin, e.s_gray, e.s_tc);
      end
      checks++;
      if ({w_dvalid, w_dbin, s_dvalid} !== 6'b0) begin
        errors++;
        $display("FAIL reset_dec: dec_valid/dec_bin got %b/%h want 0/0", w_dvalid, w_dbin);
      end
    end
  endtask

  task automatic test_up_wrap();
    logic [3:0] prev;
    prev = w_gray;
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 1, 1, 0, 0);
      e = exp_q.pop_front();
      checks++;
      if ({w_bin, w_gray, w_tc} !== {e.w_bin, e.w_gray, e.w_tc}) begin
        errors++;
        $display("FAIL up_wrap step %0d: bin/gray/tc got %h/%b/%b want %h/%b/%b", i, w_bin, w_gray, w_tc, e.w_bin, e.w_gray, e.w_tc);
      end
      checks++;
      if ($countones(w_gray ^ prev) !== 1) begin
        errors++;
        $display("FAIL up_onebit step %0d: gray %b -> %b changes %0d bits, want 1", i, prev, w_gray, $countones(w_gray ^ prev));
      end
      checks++;
      if ({s_bin, s_gray, s_tc} !== {e.s_bin, e.s_gray, e.s_tc}) begin
        errors++;
        $display("FAIL up_sat step %0d: bin/gray/tc got %h/%b/%b want %h/%b/%b", i, s_bin, s_gray, s_tc, e.s_bin, e.s_gray, e.s_tc);
      end
      prev = w_gray;
    end
    checks++;
    if ({w_bin, w_tc, s_bin, s_tc} !== {4'd0, 1'b1, 4'd15, 1'b1}) begin
      errors++;
      $display("FAIL up_bound: wrap bin/tc %h/%b sat bin/tc %h/%b want 0/1 f/1", w_bin, w_tc, s_bin, s_tc);
    end
  endtask

  task automatic test_load_priority();
    drive(0, 1, 10, 1, 1, 0, 0);
    e = exp_q.pop_front();
    checks++;
    if ({w_bin, w_gray, w_tc} !== {4'd10, 4'b1111, 1'b0} ||
        {w_bin, w_gray, w_tc} !== {e.w_bin, e.w_gray, e.w_tc}) begin
      errors++;
      $display("FAIL load_prio: bin/gray/tc got %h/%b/%b want a/1111/0", w_bin, w_gray, w_tc);
    end
    checks++;
    if ({s_bin, s_gray, s_tc} !== {e.s_bin, e.s_gray, e.s_tc}) begin
      errors++;
      $display("FAIL load_prio_sat: bin/gray/tc got %h/%b/%b want %h/%b/%b", s_bin, s_gray, s_tc, e.s_bin, e.s_gray, e.s_tc);
    end
    drive(0, 0, 0, 1, 1, 0, 0);
    e = exp_q.pop_front();
    checks++;
    if ({w_bin, w_gray, w_tc} !== {4'd11, 4'b1110, 1'b0} ||
        {w_bin, w_gray, w_tc} !== {e.w_bin, e.w_gray, e.w_tc}) begin
      errors++;
      $display("FAIL load_resume: bin/gray/tc got %h/%b/%b want b/1110/0", w_bin, w_gray, w_tc);
    end
  endtask

  task automatic test_saturate();
    logic [3:0] want_bin [4];
    logic       want_tc  [4];
    want_bin = '{4'd0, 4'd0, 4'd0, 4'd1};
    want_tc  = '{1'b0, 1'b1, 1'b1, 1'b0};
    drive(0, 1, 1, 0, 0, 0, 0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, (i == 3), 0, 0);
      e = exp_q.pop_front();
      checks++;
      if ({s_bin, s_tc} !== {want_bin[i], want_tc[i]} ||
          {s_bin, s_gray, s_tc} !== {e.s_bin, e.s_gray, e.s_tc}) begin
        errors++;
        $display("FAIL saturate step %0d: bin/gray/tc got %h/%b/%b want %h/%b/%b", i, s_bin, s_gray, s_tc, want_bin[i], e.s_gray, want_tc[i]);
      end
      checks++;
      if ({w_bin, w_gray, w_tc} !== {e.w_bin, e.w_gray, e.w_tc}) begin
        errors++;
        $display("FAIL down_wrap step %0d: bin/gray/tc got %h/%b/%b want %h/%b/%b", i, w_bin, w_gray, w_tc, e.w_bin, e.w_gray, e.w_tc);
      end
    end
  endtask

  task automatic test_decoder();
    int dg [5];
    bit dv [5];
    dg = '{13, 8, 0, 0, 0};
    dv = '{1, 1, 0, 0, 0};
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, dg[i], dv[i]);
      e = exp_q.pop_front();
      checks++;
      if ({w_dvalid, w_dbin} !== {e.d_valid, e.d_bin} ||
          {s_dvalid, s_dbin} !== {e.d_valid, e.d_bin}) begin
        errors++;
        $display("FAIL decoder cyc %0d: valid/bin got %b/%h want %b/%h", i, w_dvalid, w_dbin, e.d_valid, e.d_bin);
      end
      if (i == 1 || i == 2) begin
        checks++;
        if ({w_dvalid, w_dbin} !== {1'b1, (i == 1) ? 4'd9 : 4'd15}) begin
          errors++;
          $display("FAIL decoder_const cyc %0d: valid/bin got %b/%h want 1/%h", i, w_dvalid, w_dbin, (i == 1) ? 4'd9 : 4'd15);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      drive(0, ($urandom_range(7) == 0), $urandom_range(15), $urandom_range(1),
            $urandom_range(1), $urandom_range(15), $urandom_range(1));
      e = exp_q.pop_front();
      checks++;
      if ({w_bin, w_gray, w_tc, s_bin, s_gray, s_tc} !==
          {e.w_bin, e.w_gray, e.w_tc, e.s_bin, e.s_gray, e.s_tc}) begin
        errors++;
        $display("FAIL b2b_count cyc %0d: w %h/%b/%b s %h/%b/%b want w %h/%b/%b s %h/%b/%b", i,
                 w_bin, w_gray, w_tc, s_bin, s_gray, s_tc,
                 e.w_bin, e.w_gray, e.w_tc, e.s_bin, e.s_gray, e.s_tc);
      end
      checks++;
      if ({w_dvalid, w_dbin} !== {e.d_valid, e.d_bin}) begin
        errors++;
        $display("FAIL b2b_dec cyc %0d: valid/bin got %b/%h want %b/%h", i, w_dvalid, w_dbin, e.d_valid, e.d_bin);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 1, 7 + i, 1);
      void'(exp_q.pop_front());
    end
    drive(1, 1, 7, 1, 1, 5, 1);
    e = exp_q.pop_front();
    checks++;
    if ({w_bin, w_gray, w_tc, w_dvalid} !== 10'b0 ||
        {w_bin, w_gray, w_tc} !== {e.w_bin, e.w_gray, e.w_tc}) begin
      errors++;
      $display("FAIL rst_mid: bin/gray/tc/dec_valid got %h/%b/%b/%b want 0/0000/0/0", w_bin, w_gray, w_tc, w_dvalid);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      e = exp_q.pop_front();
      checks++;
      if ({w_dvalid, s_dvalid} !== 2'b00 || w_dvalid !== e.d_valid) begin
        errors++;
        $display("FAIL rst_flush cyc %0d: dec_valid got %b/%b want 0", i, w_dvalid, s_dvalid);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_bin = '0;
    dec_gray = '0; dec_in_valid = 1'b0;
    test_reset();
    test_up_wrap();
    test_load_priority();
    test_saturate();
    test_decoder();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
